ram_burst_reader: RTL and testbench

// Burst read engine for the 32-bit read-only side of a 16/32-bit true dual-port RAM.
// - A CPU writes the RAM through the 16-bit masked port. This block owns the 32-bit port.
// - Per request (start address, word count) it issues sequential reads.
// - It returns the words as a valid/ready stream with a last flag.
// - Typical consumers: a sprite/tile fetcher or a line-buffer loader in the video pipeline.

---
 rtl/ram_burst_reader_pkg.sv | 32 +++
 rtl/ram_burst_reader_stream_fifo2.sv | 68 ++++++
 rtl/ram_burst_reader.sv | 133 +++++++++++++
 tb/tb_ram_burst_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_reader_pkg.sv
// Shared types and constants for the 32-bit burst read engine.
// The engine and its output FIFO both use them.
package ram_burst_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int FIFO_DEPTH   = 2;
   localparam int CREDIT_WIDTH = $clog2(FIFO_DEPTH + 1);

   // One credit is taken per issued read and returned per accepted output word.
   // When a read is issued and a word is accepted in the same cycle, the count
   // does not change.
   function automatic logic [CREDIT_WIDTH-1:0] credit_next(
      input logic [CREDIT_WIDTH-1:0] cur,
      input logic                    take,
      input logic                    give
   );
      logic [CREDIT_WIDTH-1:0] nxt;
      nxt = cur;
      if (take && !give) begin
         nxt = cur - CREDIT_WIDTH'(1);
      end else if (give && !take) begin
         nxt = cur + CREDIT_WIDTH'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ram_burst_reader_stream_fifo2.sv
// Two-entry registered FIFO carrying {last, data}.
// The head entry is read directly from flops, so there is no combinational path from din to dout.
module stream_fifo2
   import ram_burst_reader_pkg::*;
#(
   parameter int WIDTH = 33
) (
   input  logic             clock,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid
);

   localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             pop_ok;

   assign pop_ok = pop && (count_q != 2'd0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop_ok})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (flush) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign valid = (count_q != 2'd0);

   // The credit scheme upstream keeps occupancy plus in-flight reads at or below the depth.
   overflow_chk: assert property (@(posedge clock) disable iff (flush)
      !(push && !pop_ok && (count_q == FULL_COUNT)));

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read engine that owns the 32-bit read port of the dual-port RAM.
// It streams each requested range of words out as a valid/ready stream with a last flag.
//
// state    | meaning
// ST_IDLE  | ready for a request; a zero-length request only pulses done
// ST_READ  | issuing sequential reads, throttled by output credits
// ST_DRAIN | all reads issued; waiting for the last word to leave the FIFO
module ram_burst_reader
   import ram_burst_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 11
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_req_valid,
   output logic                  io_req_ready,
   input  logic [ADDR_WIDTH-1:0] io_req_addr,
   input  logic [LEN_WIDTH-1:0]  io_req_len,
   output logic                  io_ram_rd,
   output logic [ADDR_WIDTH-1:0] io_ram_addr,
   input  logic [DATA_WIDTH-1:0] io_ram_dout,
   output logic                  io_out_valid,
   input  logic                  io_out_ready,
   output logic [DATA_WIDTH-1:0] io_out_data,
   output logic                  io_out_last,
   output logic                  io_busy,
   output logic                  io_done
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
   logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
   logic                    inflight_q, inflight_d;
   logic                    inflight_last_q, inflight_last_d;
   logic                    done_q, done_d;

   logic                    out_fire;
   logic                    last_fire;
   logic                    issue;
   logic                    final_issue;
   logic [DATA_WIDTH:0]     fifo_dout;
   logic                    fifo_valid;

   assign out_fire    = fifo_valid && io_out_ready;
   assign last_fire   = out_fire && fifo_dout[DATA_WIDTH];
   assign issue       = (state_q == ST_READ) && ((credits_q != '0) || out_fire);
   assign final_issue = issue && (remaining_q == LEN_WIDTH'(1));

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      remaining_d     = remaining_q;
      done_d          = 1'b0;
      inflight_d      = issue;
      inflight_last_d = final_issue;
      credits_d       = credit_next(credits_q, issue, out_fire);
      case (state_q)
         ST_IDLE: begin
            if (io_req_valid) begin
               if (io_req_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = ST_READ;
                  addr_d      = io_req_addr;
                  remaining_d = io_req_len;
               end
            end
         end
         ST_READ: begin
            if (issue) begin
               addr_d      = addr_q + ADDR_WIDTH'(1);
               remaining_d = remaining_q - LEN_WIDTH'(1);
               if (final_issue) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (last_fire) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset also clears the in-flight flag, so RAM data that returns after an abort is never pushed.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         remaining_q     <= '0;
         credits_q       <= CREDIT_WIDTH'(FIFO_DEPTH);
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         remaining_q     <= remaining_d;
         credits_q       <= credits_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         done_q          <= done_d;
      end
   end

   stream_fifo2 #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_fifo (
      .clock (clock),
      .flush (reset),
      .push  (inflight_q),
      .din   ({inflight_last_q, io_ram_dout}),
      .pop   (out_fire),
      .dout  (fifo_dout),
      .valid (fifo_valid)
   );

   assign io_req_ready = (state_q == ST_IDLE);
   assign io_busy      = (state_q != ST_IDLE);
   assign io_ram_rd    = issue;
   assign io_ram_addr  = addr_q;
   assign io_out_valid = fifo_valid;
   assign io_out_data  = fifo_dout[DATA_WIDTH-1:0];
   assign io_out_last  = fifo_valid && fifo_dout[DATA_WIDTH];
   assign io_done      = done_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: a table of bursts, a reset-abort sequence, and a RAM model.
// Expected addresses and words are queued when each request is driven.
module tb_ram_burst_reader;

   logic        clock;
   logic        reset;
   logic        io_req_valid;
   logic        io_req_ready;
   logic [9:0]  io_req_addr;
   logic [10:0] io_req_len;
   logic        io_ram_rd;
   logic [9:0]  io_ram_addr;
   logic [31:0] io_ram_dout;
   logic        io_out_valid;
   logic        io_out_ready;
   logic [31:0] io_out_data;
   logic        io_out_last;
   logic        io_busy;
   logic        io_done;

   ram_burst_reader dut (
      .clock        (clock),
      .reset        (reset),
      .io_req_valid (io_req_valid),
      .io_req_ready (io_req_ready),
      .io_req_addr  (io_req_addr),
      .io_req_len   (io_req_len),
      .io_ram_rd    (io_ram_rd),
      .io_ram_addr  (io_ram_addr),
      .io_ram_dout  (io_ram_dout),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out_data  (io_out_data),
      .io_out_last  (io_out_last),
      .io_busy      (io_busy),
      .io_done      (io_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] ram_word(input logic [9:0] a);
      return {a, ~a, 12'hA5C};
   endfunction

   // Data is valid one cycle after rd; garbage otherwise, so unrequested captures are visible.
   always @(posedge clock) begin
      io_ram_dout <= io_ram_rd ? ram_word(io_ram_addr) : 32'hDEAD_BEEF;
   end

   typedef struct {
      logic [9:0]  addr;
      logic [10:0] len;
      int          stall_lo;
      int          stall_hi;
      int          exp_last;
      int          exp_done;
      bit          spam;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   logic [9:0]  exp_addr_q [$];
   logic [32:0] exp_word_q [$];

   int          rd_cnt, first_rd, first_out, last_at, done_at, done_cnt, words;
   bit          hold_prev;
   logic [32:0] prev_word;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input int rel);
      n_checks++;
      n_errors++;
      $display("FAIL %s at relative cycle %0d", name, rel);
   endtask

   task automatic mon_clear();
      rd_cnt    = 0;
      first_rd  = -1;
      first_out = -1;
      last_at   = -1;
      done_at   = -1;
      done_cnt  = 0;
      words     = 0;
      hold_prev = 1'b0;
      prev_word = '0;
   endtask

   task automatic push_expect(input logic [9:0] addr, input logic [10:0] len);
      logic [9:0] a;
      for (int j = 0; j < int'(len); j++) begin
         a = addr + 10'(j);
         exp_addr_q.push_back(a);
         exp_word_q.push_back({(j == int'(len) - 1), ram_word(a)});
      end
   endtask

   task automatic observe(input int rel);
      if (io_ram_rd) begin
         rd_cnt++;
         if (first_rd < 0) first_rd = rel;
         if (exp_addr_q.size() == 0) fail("rd_extra", rel);
         else chk("rd_addr", io_ram_addr, exp_addr_q.pop_front());
      end
      if (io_out_valid && first_out < 0) first_out = rel;
      if (hold_prev) begin
         chk("hold_valid", io_out_valid, 1);
         chk("hold_data", {io_out_last, io_out_data}, prev_word);
      end
      hold_prev = io_out_valid && !io_out_ready;
      prev_word = {io_out_last, io_out_data};
      if (io_out_valid && io_out_ready) begin
         words++;
         if (io_out_last) last_at = rel;
         if (exp_word_q.size() == 0) fail("out_extra", rel);
         else chk("out_word", {io_out_last, io_out_data}, exp_word_q.pop_front());
      end
      if (io_done) begin
         done_cnt++;
         if (done_at < 0) done_at = rel;
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int k;
      mon_clear();
      @(posedge clock); #1;
      io_req_valid = 1'b1;
      io_req_addr  = v.addr;
      io_req_len   = v.len;
      io_out_ready = 1'b1;
      push_expect(v.addr, v.len);
      @(negedge clock);
      chk($sformatf("v%0d_req_ready", idx), io_req_ready, 1);
      observe(0);
      k = 1;
      while (k <= 80 && done_at < 0) begin
         @(posedge clock); #1;
         io_req_valid = v.spam && (k <= 3);
         io_req_addr  = 10'h055;
         io_req_len   = 11'd5;
         io_out_ready = !(k >= v.stall_lo && k <= v.stall_hi);
         @(negedge clock);
         observe(k);
         if (k == 1) begin
            chk($sformatf("v%0d_busy", idx), io_busy, (v.len != 0));
            chk($sformatf("v%0d_ready_busy", idx), io_req_ready, (v.len == 0));
         end
         if (k == v.stall_hi) chk($sformatf("v%0d_rd_before_release", idx), rd_cnt, 2);
         k++;
      end
      if (done_at < 0) fail($sformatf("v%0d_done_timeout", idx), k);
      @(posedge clock); #1;
      io_req_valid = 1'b0;
      io_out_ready = 1'b1;
      @(negedge clock);
      observe(k);
      chk($sformatf("v%0d_done_cycle", idx), done_at, v.exp_done);
      chk($sformatf("v%0d_done_count", idx), done_cnt, 1);
      chk($sformatf("v%0d_last_cycle", idx), last_at, v.exp_last);
      chk($sformatf("v%0d_words", idx), words, v.len);
      chk($sformatf("v%0d_rds", idx), rd_cnt, v.len);
      chk($sformatf("v%0d_first_rd", idx), first_rd, (v.len != 0) ? 1 : -1);
      chk($sformatf("v%0d_first_out", idx), first_out, (v.len != 0) ? 3 : -1);
      chk($sformatf("v%0d_addr_q_left", idx), exp_addr_q.size(), 0);
      chk($sformatf("v%0d_word_q_left", idx), exp_word_q.size(), 0);
      chk($sformatf("v%0d_idle_after", idx), io_busy, 0);
   endtask

   task automatic reset_abort();
      mon_clear();
      @(posedge clock); #1;
      io_req_valid = 1'b1;
      io_req_addr  = 10'h200;
      io_req_len   = 11'd16;
      io_out_ready = 1'b1;
      push_expect(10'h200, 11'd16);
      @(negedge clock);
      observe(0);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clock); #1;
         io_req_valid = 1'b0;
         reset = (k == 4);
         @(negedge clock);
         observe(k);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      exp_addr_q.delete();
      exp_word_q.delete();
      hold_prev = 1'b0;
      @(negedge clock);
      observe(5);
      chk("abort_busy", io_busy, 0);
      chk("abort_req_ready", io_req_ready, 1);
      chk("abort_out_valid", io_out_valid, 0);
      for (int k = 6; k <= 12; k++) begin
         @(posedge clock); #1;
         @(negedge clock);
         observe(k);
         chk("abort_no_stale", io_out_valid, 0);
      end
      chk("abort_no_done", done_cnt, 0);
      chk("abort_words_before_reset", words, 2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t vecs [6];
      vec_t post;
      vecs[0] = '{addr: 10'h010, len: 11'd4, stall_lo: 0, stall_hi: -1, exp_last: 6,  exp_done: 7,  spam: 1'b0};
      vecs[1] = '{addr: 10'h3FE, len: 11'd4, stall_lo: 0, stall_hi: -1, exp_last: 6,  exp_done: 7,  spam: 1'b0};
      vecs[2] = '{addr: 10'h123, len: 11'd1, stall_lo: 0, stall_hi: -1, exp_last: 3,  exp_done: 4,  spam: 1'b0};
      vecs[3] = '{addr: 10'h050, len: 11'd8, stall_lo: 3, stall_hi: 12, exp_last: 20, exp_done: 21, spam: 1'b0};
      vecs[4] = '{addr: 10'h000, len: 11'd0, stall_lo: 0, stall_hi: -1, exp_last: -1, exp_done: 1,  spam: 1'b0};
      vecs[5] = '{addr: 10'h3FF, len: 11'd3, stall_lo: 0, stall_hi: -1, exp_last: 5,  exp_done: 6,  spam: 1'b1};
      post    = '{addr: 10'h100, len: 11'd2, stall_lo: 0, stall_hi: -1, exp_last: 4,  exp_done: 5,  spam: 1'b0};

      reset        = 1'b1;
      io_req_valid = 1'b0;
      io_req_addr  = '0;
      io_req_len   = '0;
      io_out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_req_ready", io_req_ready, 1);
      chk("rst_busy", io_busy, 0);
      chk("rst_out_valid", io_out_valid, 0);
      chk("rst_ram_rd", io_ram_rd, 0);
      chk("rst_done", io_done, 0);
      chk("rst_out_last", io_out_last, 0);
      chk("rst_out_data", io_out_data, 0);
      chk("rst_ram_addr", io_ram_addr, 0);

      for (int i = 0; i < 6; i++) begin
         run_vec(i, vecs[i]);
      end

      reset_abort();
      run_vec(6, post);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
